cjump_rs: RTL
=============

# cjump_rs

Reservation station for the conditional-jump functional unit. It holds up to DEPTH dispatched cjump micro-ops and captures their two source operands from the CDB as they are broadcast. Each cycle it issues the oldest fully-ready entry to the cjump FU's input port. It sits between dispatch/rename and the FU, and takes backpressure from the FU's pending-writeback state.

## Interface
- DEPTH, 4: number of entries, 2..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- disp_transmit  in  1  dispatch request
- disp_ready  out  1  station can accept a dispatch this cycle
- disp_operand  in  8  operand; condition mask in [7:4]
- disp_dep_tag  in  2x4  source tags, index 0 = a, 1 = b
- disp_dep_rdy  in  2  source value already present
- disp_dep_val  in  2x8  source values, valid where disp_dep_rdy set
- disp_wbs  in  8  writeback selector; [3:0] is the result tag
- disp_flags  in  8  incoming flags
- disp_robid  in  4  ROB index
- cdb_transmit  in  1  CDB broadcast valid
- cdb_id  in  4  broadcast tag
- cdb_val  in  8  broadcast value
- fu_stall  in  1  FU holds an unsent result; must be driven from FU registered state, never combinationally from issue_transmit
- issue_transmit  out  1  issue valid; drives FU input_transmit
- issue_operand  out  8
- issue_depvals  out  2x8
- issue_wbs  out  8
- issue_flags  out  8
- issue_robid  out  4
- occupancy  out  4  valid entry count

## Operation
- Collapsing queue. Index 0 is the oldest entry. Each entry holds valid, operand, tag[2], rdy[2], val[2], wbs, flags, robid.
- An entry is ready when valid & rdy[0] & rdy[1].
- Issue, combinational: issue_transmit = ~fu_stall & (any ready entry).
  - The lowest-index ready entry is selected.
  - Payload outputs carry that entry's fields. They are 0 when issue_transmit is low.
- Issue is fire-and-forget. At the clock edge the issued entry is removed, and entries above it shift down one index.
- Dispatch: accepted when disp_transmit & disp_ready. disp_ready = (occupancy < DEPTH), computed without crediting a same-cycle issue.
  - The new entry is written at index (occupancy minus 1 if an issue occurs this cycle), which places it behind all survivors.
  - A dispatch while disp_ready is low is ignored; no state changes.
- CDB capture: on cdb_transmit, every valid entry with rdy[i]=0 and tag[i]==cdb_id sets rdy[i] and loads val[i]=cdb_val. Both sources may match the same broadcast.
- Dispatch/CDB collision: if the broadcast matches a dispatching entry's not-ready source, that source is captured ready at write.
- Entries are neither age-blocked nor reordered. A younger ready entry issues past an older unready one.
- flush: all valid bits clear at the edge. flush takes priority over the same-cycle dispatch and capture. issue_transmit is still driven combinationally in the flush cycle; the FU squash is handled by the ROB.
- Reset, asynchronous: all valid and rdy bits are 0, occupancy 0, issue_transmit 0, payload outputs 0, disp_ready 1.

## Timing
- Dispatch→issue latency is at least 1 cycle. An entry written at edge t can issue in cycle t+1 if ready.
- CDB→issue: a value broadcast in cycle t makes the entry eligible in cycle t+1. There is no same-cycle bypass to issue.
- Throughput is 1 issue per cycle while fu_stall is low.
- fu_stall high in cycle t means no issue in cycle t. Entry contents still update from dispatch and CDB.
- When full with an issue in the same cycle, occupancy stays at DEPTH. Dispatch is refused that cycle and accepted the next.
- Reset is released synchronously to clk by the top level. The block does not resynchronise it.

## Test plan
- Dispatch {operand=0x50, deps rdy, a=0x80, b=0x3C, wbs=0x07, robid=3} into an empty station.
  - Cycle+1: issue_transmit=1, depvals={0x80,0x3C}, robid=3.
  - Cycle+2: occupancy=0.
- Dispatch A (tag[0]=5, not ready), then B (ready).
  - B issues first.
  - CDB id=5 val=0x01 → A issues on the next cycle with depvals[0]=0x01.
- Dispatch with tag[1]=9 not ready while the same cycle carries CDB id=9 val=0xAA.
  - Entry captured ready; it issues next cycle with b=0xAA.
- Fill DEPTH entries with unready sources.
  - disp_ready=0 and a dispatch is ignored.
  - Broadcast one tag so entry 2 becomes ready → it issues, entries shift, occupancy=DEPTH-1, disp_ready=1.
- Hold fu_stall=1 with 3 ready entries.
  - No issue.
  - Release → issues in index order, one per cycle, over 3 cycles.
- Assert rst low mid-operation, async between edges.
  - Outputs go to reset values immediately.
  - Assert flush with a concurrent dispatch → occupancy=0 next cycle.

Source files
------------

// File: rtl/cjump_rs.sv
// Reservation station for the conditional-jump FU: a collapsing queue that
// captures CDB operands and issues the oldest ready entry each cycle.
module cjump_rs #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            disp_transmit,
  output logic            disp_ready,
  input  logic [7:0]      disp_operand,
  input  logic [1:0][3:0] disp_dep_tag,
  input  logic [1:0]      disp_dep_rdy,
  input  logic [1:0][7:0] disp_dep_val,
  input  logic [7:0]      disp_wbs,
  input  logic [7:0]      disp_flags,
  input  logic [3:0]      disp_robid,
  input  logic            cdb_transmit,
  input  logic [3:0]      cdb_id,
  input  logic [7:0]      cdb_val,
  input  logic            fu_stall,
  output logic            issue_transmit,
  output logic [7:0]      issue_operand,
  output logic [1:0][7:0] issue_depvals,
  output logic [7:0]      issue_wbs,
  output logic [7:0]      issue_flags,
  output logic [3:0]      issue_robid,
  output logic [3:0]      occupancy
);

  // Handshakes: a dispatch transfers when disp_transmit & disp_ready at the
  // rising edge; issue is fire-and-forget, the FU takes every cycle in which
  // issue_transmit is high and backpressure arrives only through fu_stall.

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic            valid;
    logic [7:0]      operand;
    logic [1:0][3:0] tag;
    logic [1:0]      rdy;
    logic [1:0][7:0] val;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
  } entry_t;

  entry_t q       [DEPTH];
  entry_t q_nxt   [DEPTH];
  entry_t shifted [DEPTH];
  entry_t new_e;
  entry_t issue_e;

  logic [DEPTH-1:0] ready_vec;
  logic             any_ready;
  logic [IW-1:0]    sel_idx;
  logic             issue_fire;
  logic             disp_acc;
  logic [3:0]       occ_cnt;
  logic [3:0]       wr_idx;

  function automatic entry_t capture(input entry_t e, input logic bc_v,
                                     input logic [3:0] bc_id, input logic [7:0] bc_val);
    entry_t r;
    r = e;
    for (int s = 0; s < 2; s++) begin
      if (bc_v && r.valid && !r.rdy[s] && (r.tag[s] == bc_id)) begin
        r.rdy[s] = 1'b1;
        r.val[s] = bc_val;
      end
    end
    return r;
  endfunction

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = q[i].valid & q[i].rdy[0] & q[i].rdy[1];
      occ_cnt      = occ_cnt + 4'(q[i].valid);
    end
  end

  // Scan from the top so the lowest ready index wins.
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        any_ready = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign issue_fire = ~fu_stall & any_ready;
  assign disp_ready = (occ_cnt < 4'(DEPTH));
  assign disp_acc   = disp_transmit & disp_ready;
  assign wr_idx     = occ_cnt - 4'(issue_fire);
  assign occupancy  = occ_cnt;

  always_comb begin
    issue_e = '0;
    if (issue_fire) issue_e = q[sel_idx];
  end

  assign issue_transmit = issue_fire;
  assign issue_operand  = issue_e.operand;
  assign issue_depvals  = issue_e.val;
  assign issue_wbs      = issue_e.wbs;
  assign issue_flags    = issue_e.flags;
  assign issue_robid    = issue_e.robid;

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.operand = disp_operand;
    new_e.tag     = disp_dep_tag;
    new_e.rdy     = disp_dep_rdy;
    new_e.val     = disp_dep_val;
    new_e.wbs     = disp_wbs;
    new_e.flags   = disp_flags;
    new_e.robid   = disp_robid;
  end

  // Collapse over the issued slot, then apply capture, dispatch and flush.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) shifted[i] = q[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) shifted[i] = q[i + 1];
    end
    if (issue_fire) shifted[DEPTH-1] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = capture(shifted[i], cdb_transmit, cdb_id, cdb_val);
      if (disp_acc && (wr_idx == 4'(i)))
        q_nxt[i] = capture(new_e, cdb_transmit, cdb_id, cdb_val);
      if (flush) q_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
    end
  end

endmodule
